// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcodes, flag indices and data width for the 16-bit ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int DATA_W = 16;

  typedef logic [DATA_W-1:0] word_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_NOT  = 3'b100;
  localparam logic [2:0] OP_INC  = 3'b101;
  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_SETC = 3'b111;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
// Module      : alu_core
// Description : Combinational result and next-flag computation for the ALU.
//               ALU_OVERFLOW_FLAG_EN: drive V from signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_core
  import alu_pkg::*;
(
  input  logic [15:0] i_operand1,
  input  logic [15:0] i_operand2,
  input  logic [2:0]  i_operation,
  input  logic [3:0]  i_flags,
  output logic [15:0] o_result,
  output logic [3:0]  o_flags
);

  logic [16:0] w_ext;
  logic [2:0]  w_znc;

  always_comb begin
    w_ext = {1'b0, i_operand1};
    w_znc = i_flags[2:0];
    case (i_operation)
      OP_ADD: begin
        w_ext = {1'b0, i_operand1} + {1'b0, i_operand2};
        w_znc[FLAG_C] = w_ext[16];
      end
      OP_SUB: begin
        // Bit 16 of the wrapped 17-bit difference is the borrow.
        w_ext = {1'b0, i_operand1} - {1'b0, i_operand2};
        w_znc[FLAG_C] = w_ext[16];
      end
      OP_AND:  w_ext = {1'b0, i_operand1 & i_operand2};
      OP_OR:   w_ext = {1'b0, i_operand1 | i_operand2};
      OP_NOT:  w_ext = {1'b0, ~i_operand1};
      OP_INC: begin
        w_ext = {1'b0, i_operand1} + 17'd1;
        w_znc[FLAG_C] = w_ext[16];
      end
      OP_SETC: w_znc[FLAG_C] = 1'b1;
      default: ;
    endcase
    if (i_operation <= OP_INC) begin
      w_znc[FLAG_Z] = (w_ext[15:0] == 16'h0000);
      w_znc[FLAG_N] = w_ext[15];
    end
  end

  assign o_result = w_ext[15:0];

`ifdef ALU_OVERFLOW_FLAG_EN
  logic w_v;

  always_comb begin
    w_v = i_flags[FLAG_V];
    case (i_operation)
      OP_ADD:  w_v = (i_operand1[15] == i_operand2[15]) && (w_ext[15] != i_operand1[15]);
      OP_SUB:  w_v = (i_operand1[15] != i_operand2[15]) && (w_ext[15] != i_operand1[15]);
      OP_INC:  w_v = ~i_operand1[15] & w_ext[15];
      default: ;
    endcase
  end

  assign o_flags = {w_v, w_znc};
`else
  assign o_flags = {i_flags[FLAG_V], w_znc};
`endif

endmodule

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module      : alu
// Description : 16-bit registered ALU; result and flags valid one cycle later.
//               ALU_OVERFLOW_FLAG_EN: enable signed-overflow V flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] operand1,
  input  logic [15:0] operand2,
  input  logic [2:0]  operation,
  input  logic [3:0]  flags_in,
  output logic [15:0] result,
  output logic [3:0]  flags_out
);

  logic [15:0] w_result;
  logic [3:0]  w_flags;
  logic [15:0] r_result;
  logic [3:0]  r_flags;

  alu_core u_core (
    .i_operand1  (operand1),
    .i_operand2  (operand2),
    .i_operation (operation),
    .i_flags     (flags_in),
    .o_result    (w_result),
    .o_flags     (w_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= 16'h0000;
      r_flags  <= 4'b0000;
    end else begin
      r_result <= w_result;
      r_flags  <= w_flags;
    end
  end

  assign result    = r_result;
  assign flags_out = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// ============================================================================
// Module      : tb_alu
// Description : Directed and random checks of alu against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] operand1;
  logic [15:0] operand2;
  logic [2:0]  operation;
  logic [3:0]  flags_in;
  logic [15:0] result;
  logic [3:0]  flags_out;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  alu dut (
    .clk       (clk),
    .rst       (rst),
    .operand1  (operand1),
    .operand2  (operand2),
    .operation (operation),
    .flags_in  (flags_in),
    .result    (result),
    .flags_out (flags_out)
  );

  // Reference: {result, flags} from integer arithmetic on the operation rules.
  function automatic logic [19:0] model(logic [15:0] a, logic [15:0] b,
                                        logic [2:0] op, logic [3:0] fin);
    int   ua = int'(a);
    int   ub = int'(b);
    int   full;
    logic [15:0] r;
    logic z = fin[0], n = fin[1], c = fin[2], v = fin[3];
`ifdef ALU_OVERFLOW_FLAG_EN
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int sfull;
`endif
    case (op)
      3'd0: begin full = ua + ub; c = (full > 65535); end
      3'd1: begin full = ua - ub; c = (ua < ub);      end
      3'd2: full = ua & ub;
      3'd3: full = ua | ub;
      3'd4: full = ~ua;
      3'd5: begin full = ua + 1;  c = (full > 65535); end
      3'd6: full = ua;
      default: begin full = ua; c = 1'b1; end
    endcase
    r = full[15:0];
    if (op <= 3'd5) begin
      z = (r == 16'h0000);
      n = r[15];
    end
`ifdef ALU_OVERFLOW_FLAG_EN
    if (op == 3'd0 || op == 3'd1 || op == 3'd5) begin
      sfull = (op == 3'd0) ? sa + sb : (op == 3'd1) ? sa - sb : sa + 1;
      v = (sfull > 32767) || (sfull < -32768);
    end
`endif
    return {r, v, c, n, z};
  endfunction

  task automatic check(string tag, logic [15:0] exp_r, logic [3:0] exp_f);
    n_total++;
    assert (result === exp_r) n_pass++;
    else $error("FAIL %s result: got %h expected %h", tag, result, exp_r);
    n_total++;
    assert (flags_out === exp_f) n_pass++;
    else $error("FAIL %s flags: got %b expected %b", tag, flags_out, exp_f);
  endtask

  // Drive one operation, clock it in, then compare after the edge.
  task automatic step(string tag, logic r, logic [15:0] a, logic [15:0] b,
                      logic [2:0] op, logic [3:0] fin, logic [15:0] exp_r,
                      logic [3:0] exp_f);
    rst = r; operand1 = a; operand2 = b; operation = op; flags_in = fin;
    @(posedge clk);
    #1;
    check(tag, exp_r, exp_f);
  endtask

  initial begin
    logic [19:0] m;
    logic [15:0] a, b;
    logic [2:0]  op;
    logic [3:0]  fin;

    rst = 1'b1; operand1 = 16'h1234; operand2 = 16'h5678;
    operation = 3'd0; flags_in = 4'b1111;
    @(posedge clk); @(posedge clk); #1;
    check("reset", 16'h0000, 4'b0000);

    step("add_0ffe", 1'b0, 16'h0ffe, 16'h0000, 3'd0, 4'b0000, 16'h0ffe, 4'b0000);
    step("add_ffff_ffff", 1'b0, 16'hffff, 16'hffff, 3'd0, 4'b0000, 16'hfffe, 4'b0110);
    step("add_zero_cin", 1'b0, 16'h0000, 16'h0000, 3'd0, 4'b0100, 16'h0000, 4'b0001);
    step("and_keep_c", 1'b0, 16'hffff, 16'h0001, 3'd2, 4'b0100, 16'h0001, 4'b0100);
    step("sub_borrow", 1'b0, 16'h0ffe, 16'h0fff, 3'd1, 4'b0000, 16'hffff, 4'b0110);
    step("inc_wrap", 1'b0, 16'hffff, 16'h0000, 3'd5, 4'b0000, 16'h0000, 4'b0101);
    step("mov_keep", 1'b0, 16'h8000, 16'h0000, 3'd6, 4'b1011, 16'h8000, 4'b1011);
    step("setc", 1'b0, 16'h0000, 16'h0000, 3'd7, 4'b1000, 16'h0000, 4'b1100);
    step("rst_mid_op", 1'b1, 16'hffff, 16'h0001, 3'd0, 4'b0000, 16'h0000, 4'b0000);
    step("post_rst_op", 1'b0, 16'hffff, 16'h0001, 3'd0, 4'b0000, 16'h0000, 4'b0101);
`ifdef ALU_OVERFLOW_FLAG_EN
    step("add_ovf", 1'b0, 16'h7fff, 16'h0001, 3'd0, 4'b0000, 16'h8000, 4'b1010);
    step("sub_ovf", 1'b0, 16'h8000, 16'h0001, 3'd1, 4'b0000, 16'h7fff, 4'b1000);
`else
    step("v_passthru", 1'b0, 16'h7fff, 16'h0001, 3'd0, 4'b1000, 16'h8000, 4'b1010);
`endif

    for (int i = 0; i < 300; i++) begin
      a   = 16'($urandom);
      b   = 16'($urandom);
      op  = 3'($urandom_range(0, 7));
      fin = 4'($urandom);
      if (i % 7 == 0) b = a;
      if (i % 11 == 0) a = 16'hffff;
      m = model(a, b, op, fin);
      step($sformatf("rand%0d_op%0d", i, op), 1'b0, a, b, op, fin, m[19:4], m[3:0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
